phy_id_freelist: RTL and testbench

//  Allocator for physical register IDs of phy_regfile; the resource scheduler between rename and commit.
//  - Circular buffer of free phy IDs with a speculative read pointer (rename) and a committed read pointer (commit).
//  - Commit releases old mappings.
//  - Flush rewinds speculative allocation to the committed state.

---
 rtl/phy_id_freelist_pkg.sv | 18 +
 rtl/phy_id_freelist_popcount_prefix.sv | 23 ++
 rtl/phy_id_freelist.sv | 126 ++++++++++++
 tb/tb_phy_id_freelist.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/phy_id_freelist_pkg.sv
// Shared configuration and types for the physical register ID free list.
package phy_id_freelist_pkg;

  localparam int unsigned PHY_REG_NUM      = 64;
  localparam int unsigned ARCH_REG_NUM     = 32;
  localparam int unsigned RENAME_WIDTH     = 2;
  localparam int unsigned COMMIT_WIDTH     = 2;
  localparam int unsigned PHY_REG_ID_WIDTH = $clog2(PHY_REG_NUM);

  typedef logic [PHY_REG_ID_WIDTH-1:0] phy_id_t;
  typedef logic [PHY_REG_ID_WIDTH:0]   phy_ptr_t;

  // Buffer index of a wrap-bit pointer.
  function automatic phy_id_t ptr_idx(input phy_ptr_t p);
    return phy_id_t'(p);
  endfunction

endpackage

// File: rtl/phy_id_freelist_popcount_prefix.sv
// Exclusive prefix popcount of each input bit plus the total count.
module popcount_prefix #(
  parameter  int unsigned W  = 2,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]         i_bits,
  output logic [W-1:0][CW-1:0] o_prefix,
  output logic [CW-1:0]        o_total
);

  logic [CW-1:0] w_acc;

  always_comb begin
    w_acc    = '0;
    o_prefix = '0;
    for (int i = 0; i < int'(W); i++) begin
      o_prefix[i] = w_acc;
      w_acc       = w_acc + CW'(i_bits[i]);
    end
    o_total = w_acc;
  end

endmodule

// File: rtl/phy_id_freelist.sv
// Circular free list of physical register IDs with speculative (rename) and
// committed read pointers; flush rewinds the speculative pointer.
module phy_id_freelist
  import phy_id_freelist_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic [RENAME_WIDTH-1:0]           i_rename_freelist_valid,
  output logic                              o_freelist_rename_ready,
  output phy_id_t [RENAME_WIDTH-1:0]        o_freelist_rename_phy_id,
  input  logic [COMMIT_WIDTH-1:0]           i_commit_freelist_retire,
  input  phy_id_t [COMMIT_WIDTH-1:0]        i_commit_freelist_release_id,
  input  logic [COMMIT_WIDTH-1:0]           i_commit_freelist_release_we,
  input  logic                              i_commit_freelist_flush,
  output phy_ptr_t                          o_freelist_free_count
);

  localparam int unsigned RCW       = $clog2(RENAME_WIDTH + 1);
  localparam int unsigned CCW       = $clog2(COMMIT_WIDTH + 1);
  localparam int unsigned FREE_INIT = PHY_REG_NUM - ARCH_REG_NUM;
  localparam phy_ptr_t    DEPTH_P   = phy_ptr_t'(PHY_REG_NUM);
  localparam phy_ptr_t    INIT_P    = phy_ptr_t'(FREE_INIT);
  localparam phy_ptr_t    RW_P      = phy_ptr_t'(RENAME_WIDTH);

  phy_id_t  r_buf [PHY_REG_NUM];
  phy_ptr_t r_wptr;
  phy_ptr_t r_spec_rptr;
  phy_ptr_t r_commit_rptr;

  logic [RENAME_WIDTH-1:0][RCW-1:0] w_alloc_prefix;
  logic [RCW-1:0]                   w_alloc_total;
  logic [COMMIT_WIDTH-1:0][CCW-1:0] w_rel_prefix;
  logic [CCW-1:0]                   w_rel_total;
  logic [COMMIT_WIDTH-1:0][CCW-1:0] w_ret_prefix;
  logic [CCW-1:0]                   w_ret_total;

  phy_ptr_t w_free_count;
  logic     w_ready;
  logic     w_fire;
  phy_ptr_t w_wptr_nxt;
  phy_ptr_t w_commit_nxt;
  phy_ptr_t w_spec_nxt;

  popcount_prefix #(.W(RENAME_WIDTH)) u_alloc_pc (
    .i_bits   (i_rename_freelist_valid),
    .o_prefix (w_alloc_prefix),
    .o_total  (w_alloc_total)
  );

  popcount_prefix #(.W(COMMIT_WIDTH)) u_release_pc (
    .i_bits   (i_commit_freelist_release_we),
    .o_prefix (w_rel_prefix),
    .o_total  (w_rel_total)
  );

  // Only the retire total is needed; the per-lane prefix is left open.
  popcount_prefix #(.W(COMMIT_WIDTH)) u_retire_pc (
    .i_bits   (i_commit_freelist_retire),
    .o_prefix (w_ret_prefix),
    .o_total  (w_ret_total)
  );

  // Readiness is conservative: it ignores how many lanes actually request.
  always_comb begin
    w_free_count = r_wptr - r_spec_rptr;
    w_ready      = (w_free_count >= RW_P) && !i_commit_freelist_flush;
    w_fire       = w_ready && (|i_rename_freelist_valid);
    w_wptr_nxt   = r_wptr + phy_ptr_t'(w_rel_total);
    w_commit_nxt = r_commit_rptr + phy_ptr_t'(w_ret_total);
    w_spec_nxt   = r_spec_rptr;
    if (i_commit_freelist_flush) begin
      w_spec_nxt = w_commit_nxt;
    end else if (w_fire) begin
      w_spec_nxt = r_spec_rptr + phy_ptr_t'(w_alloc_total);
    end
  end

  // Compacted read lanes: lane i takes the entry after all lower requesting lanes.
  always_comb begin
    o_freelist_rename_phy_id = '0;
    for (int i = 0; i < int'(RENAME_WIDTH); i++) begin
      o_freelist_rename_phy_id[i] =
        r_buf[ptr_idx(r_spec_rptr + phy_ptr_t'(w_alloc_prefix[i]))];
    end
  end

  assign o_freelist_rename_ready = w_ready;
  assign o_freelist_free_count   = w_free_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr        <= INIT_P;
      r_spec_rptr   <= '0;
      r_commit_rptr <= '0;
    end else begin
      r_wptr        <= w_wptr_nxt;
      r_spec_rptr   <= w_spec_nxt;
      r_commit_rptr <= w_commit_nxt;
    end
  end

  // Released IDs land at consecutive slots starting at wptr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(PHY_REG_NUM); k++) begin
        r_buf[k] <= (k < int'(FREE_INIT)) ? phy_id_t'(int'(ARCH_REG_NUM) + k) : '0;
      end
    end else begin
      for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
        if (i_commit_freelist_release_we[i]) begin
          r_buf[ptr_idx(r_wptr + phy_ptr_t'(w_rel_prefix[i]))] <= i_commit_freelist_release_id[i];
        end
      end
    end
  end

  a_no_overfill: assert property (@(posedge clk) disable iff (rst)
    phy_ptr_t'(w_wptr_nxt - w_commit_nxt) <= DEPTH_P);

  a_spec_bound: assert property (@(posedge clk) disable iff (rst)
    phy_ptr_t'(r_spec_rptr - r_commit_rptr) <= INIT_P);

  a_retire_behind_spec: assert property (@(posedge clk) disable iff (rst)
    phy_ptr_t'(w_ret_total) <= phy_ptr_t'(r_spec_rptr - r_commit_rptr));

endmodule

// File: tb/tb_phy_id_freelist.sv
// Directed bench for phy_id_freelist against an unbounded-sequence model of the free list.
module tb_phy_id_freelist;
  import phy_id_freelist_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        valid;
  logic [1:0]        retire;
  logic [1:0]        we;
  phy_id_t [1:0]     rel_id;
  logic              flush;
  logic              ready;
  phy_id_t [1:0]     phy_id;
  phy_ptr_t          free_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit m_live  = 1'b0;

  // Model: every ID ever made free, in order; c/s/w are plain positions in it.
  int m_hist[$];
  int m_c, m_s, m_w;

  always #5 clk = ~clk;

  phy_id_freelist dut (
    .clk                          (clk),
    .rst                          (rst),
    .i_rename_freelist_valid      (valid),
    .o_freelist_rename_ready      (ready),
    .o_freelist_rename_phy_id     (phy_id),
    .i_commit_freelist_retire     (retire),
    .i_commit_freelist_release_id (rel_id),
    .i_commit_freelist_release_we (we),
    .i_commit_freelist_flush      (flush),
    .o_freelist_free_count        (free_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pc2(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  task automatic model_reset();
    m_hist.delete();
    for (int k = 0; k < 32; k++) m_hist.push_back(32 + k);
    m_c = 0;
    m_s = 0;
    m_w = 32;
  endtask

  task automatic model_update();
    bit rdy;
    rdy = ((m_w - m_s) >= 2) && !flush;
    for (int i = 0; i < 2; i++) begin
      if (we[i]) begin
        m_hist.push_back(int'(rel_id[i]));
        m_w++;
      end
    end
    m_c += pc2(retire);
    if (flush) m_s = m_c;
    else if (rdy && valid != 2'b00) m_s += pc2(valid);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] r, input logic [1:0] w,
                       input int id0, input int id1, input logic f);
    valid  = v;
    retire = r;
    we     = w;
    rel_id[0] = phy_id_t'(id0);
    rel_id[1] = phy_id_t'(id1);
    flush  = f;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle();
    model_reset();
    #1;
    chk("rst_free_count", 32'(free_cnt), 32);
    chk("rst_phy_id0", 32'(phy_id[0]), 32);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 1);
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    if (!rst && m_live) begin
      int p;
      bit mrdy;
      mrdy = ((m_w - m_s) >= 2) && !flush;
      chk("free_count", 32'(free_cnt), 32'(m_w - m_s));
      chk("ready", 32'(ready), 32'(mrdy));
      chk("free_bound", 32'(free_cnt <= 7'd64), 1);
      if (mrdy) begin
        for (int i = 0; i < 2; i++) begin
          if (valid[i]) begin
            p = m_s + ((i == 1) ? int'(valid[0]) : 0);
            if (p < m_hist.size()) chk("phy_id", 32'(phy_id[i]), 32'(m_hist[p]));
            else chk("model_index", 32'(p), 32'(m_hist.size() - 1));
          end
        end
      end
    end
  end

  initial begin
    int outstanding, nr;
    logic [1:0] rp, vp;
    rst = 1'b1;
    idle();
    model_reset();
    reset_dut();
    m_live = 1'b1;

    // Two-lane alloc from reset, then one-lane alloc on the upper lane.
    drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
    #1;
    chk("t1_id0", 32'(phy_id[0]), 32);
    chk("t1_id1", 32'(phy_id[1]), 33);
    tick();
    idle();
    #1;
    chk("t1_free", 32'(free_cnt), 30);
    chk("t1_next_id0", 32'(phy_id[0]), 34);
    drive(2'b10, 2'b00, 2'b00, 0, 0, 1'b0);
    #1;
    chk("t2_id1", 32'(phy_id[1]), 34);
    tick();
    idle();
    #1;
    chk("t2_free", 32'(free_cnt), 29);
    chk("t2_id0", 32'(phy_id[0]), 35);

    // Asynchronous reset in the middle of traffic.
    drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
    reset_dut();

    // Drain to a single free entry, then release phy 5.
    for (int k = 0; k < 15; k++) begin
      drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
      tick();
    end
    drive(2'b01, 2'b00, 2'b00, 0, 0, 1'b0);
    tick();
    drive(2'b11, 2'b01, 2'b01, 5, 0, 1'b0);
    #1;
    chk("t3_ready_low", 32'(ready), 0);
    chk("t3_free1", 32'(free_cnt), 1);
    tick();
    drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
    #1;
    chk("t3_ready_back", 32'(ready), 1);
    chk("t3_old_id", 32'(phy_id[0]), 63);
    chk("t3_released_id", 32'(phy_id[1]), 5);
    tick();
    idle();
    tick();

    // Allocate six, retire two, flush while retiring one more.
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
      tick();
    end
    drive(2'b00, 2'b11, 2'b00, 0, 0, 1'b0);
    tick();
    drive(2'b00, 2'b01, 2'b00, 0, 0, 1'b1);
    #1;
    chk("t4_flush_ready", 32'(ready), 0);
    tick();
    drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
    #1;
    chk("t4_reoffer0", 32'(phy_id[0]), 35);
    chk("t4_reoffer1", 32'(phy_id[1]), 36);
    chk("t4_free", 32'(free_cnt), 29);
    tick();

    // Flush colliding with an alloc request and a release.
    reset_dut();
    drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0);
    tick();
    drive(2'b11, 2'b00, 2'b01, 9, 0, 1'b1);
    #1;
    chk("t5_ready", 32'(ready), 0);
    chk("t5_free_before", 32'(free_cnt), 30);
    tick();
    idle();
    #1;
    chk("t5_free_restored", 32'(free_cnt), 33);
    chk("t5_id0", 32'(phy_id[0]), 32);
    tick();

    // Long alloc/retire/release run wrapping the pointers several times.
    reset_dut();
    for (int cyc = 0; cyc < 160; cyc++) begin
      outstanding = m_s - m_c;
      nr = (outstanding > 2) ? 2 : outstanding;
      rp = (nr == 2) ? 2'b11 : (nr == 1) ? ((cyc % 2 == 1) ? 2'b01 : 2'b10) : 2'b00;
      vp = (cyc % 4 == 3) ? 2'b01 : (cyc % 5 == 0) ? 2'b10 : 2'b11;
      drive(vp, rp, rp, (cyc * 5 + 1) % 64, (cyc * 5 + 2) % 64, (cyc % 37 == 36));
      tick();
    end
    idle();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
